// File: rtl/local_maxima_collector.sv
// rtl/local_maxima_collector.sv - queues coordinates/values of flagged pixels from a raster stream
module local_maxima_collector #(
  parameter int WIDTH  = 6,
  parameter int HEIGHT = 6,
  parameter int DEPTH  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_flag,
  input  logic [7:0] in_pixel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_row,
  output logic [7:0] out_col,
  output logic [7:0] out_value,
  output logic [7:0] max_count,
  output logic       overflow,
  output logic       frame_done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FLUSH} state_e;

  state_e             state_q, state_d;
  logic               done_q, done_d;
  logic [7:0]         row_q, col_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [23:0]        mem_q [DEPTH];
  logic [7:0]         max_q, max_d;
  logic               ovf_q, ovf_d;

  logic accept, pop, push, push_ok, full, last_pix, frame_start;

  assign accept      = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign last_pix    = (row_q == 8'(HEIGHT)) && (col_q == 8'(WIDTH));
  assign full        = (count_q == CNT_W'(DEPTH)) && !pop;
  assign push        = accept && in_flag;
  assign push_ok     = push && !full;
  assign frame_start = accept && (state_q == S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // done_q marks the single pulse cycle; FLUSH is held through it so in_ready stays low
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = last_pix ? S_FLUSH : S_COLLECT;
      end
      S_COLLECT: begin
        if (accept && last_pix) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (done_q)              state_d = S_IDLE;
        else if (count_q == '0)  done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state_q != S_FLUSH);
    frame_done = done_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= 8'd1;
      col_q <= 8'd1;
    end else if (accept) begin
      if (last_pix) begin
        row_q <= 8'd1;
        col_q <= 8'd1;
      end else if (col_q == 8'(WIDTH)) begin
        row_q <= row_q + 8'd1;
        col_q <= 8'd1;
      end else begin
        col_q <= col_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= {row_q, col_q, in_pixel};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Statistics clear on the frame's first accept, then that same pixel is counted
  always_comb begin
    max_d = max_q;
    ovf_d = ovf_q;
    if (frame_start) begin
      max_d = 8'd0;
      ovf_d = 1'b0;
    end
    if (push && (max_d != 8'hFF)) max_d = max_d + 8'd1;
    if (push && full)             ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_q <= 8'd0;
      ovf_q <= 1'b0;
    end else begin
      max_q <= max_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_valid                     = (count_q != '0);
  assign {out_row, out_col, out_value} = mem_q[rd_ptr_q];
  assign max_count                     = max_q;
  assign overflow                      = ovf_q;

endmodule

// File: tb/tb_local_maxima_collector.sv
// tb/tb_local_maxima_collector.sv - directed bench for local_maxima_collector
module tb_local_maxima_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_flag;
  logic [7:0] in_pixel;
  logic       out_valid, out_ready;
  logic [7:0] out_row, out_col, out_value, max_count;
  logic       overflow, frame_done;

  int tests = 0;
  int fails = 0;
  logic [23:0] got[$];

  always #5 clk = ~clk;

  local_maxima_collector #(.WIDTH(6), .HEIGHT(6), .DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_flag(in_flag), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .out_value(out_value),
    .max_count(max_count), .overflow(overflow), .frame_done(frame_done)
  );

  function automatic logic [23:0] ent(input int k, input int v);
    return {8'(k / 6 + 1), 8'(k % 6 + 1), 8'(v)};
  endfunction

  // one clock; records the head if it is popped at this edge
  task automatic cyc();
    if (out_valid && out_ready) got.push_back({out_row, out_col, out_value});
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pix(input int k, input logic flag, input int v);
    in_valid = 1'b1;
    in_flag  = flag;
    in_pixel = 8'(v);
    cyc();
    in_valid = 1'b0;
    in_flag  = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
      cyc();
    end
    if (seen) cyc();
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_flag = 1'b0; in_pixel = 8'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++; if (max_count !== 8'd0 || overflow !== 1'b0 || frame_done !== 1'b0) begin
      fails++; $display("FAIL reset_stats: got mc=%0d ovf=%b fd=%b expected 0 0 0", max_count, overflow, frame_done); end
    tests++; if ({out_row, out_col, out_value} !== 24'h0) begin
      fails++; $display("FAIL reset_head: got %h expected 000000", {out_row, out_col, out_value}); end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_single_peak();
    got.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 36; k++) drive_pix(k, k == 15, (k == 15) ? 200 : 0);
    tests++; if (in_ready !== 1'b0 || frame_done !== 1'b0) begin
      fails++; $display("FAIL peak_flush_entry: got rdy=%b fd=%b expected 0 0", in_ready, frame_done); end
    cyc();
    tests++; if (frame_done !== 1'b1) begin fails++; $display("FAIL peak_done_pulse: got %b expected 1", frame_done); end
    cyc();
    tests++; if (frame_done !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL peak_done_end: got fd=%b rdy=%b expected 0 1", frame_done, in_ready); end
    tests++; if (got.size() != 1 || got[0] !== ent(15, 200)) begin
      fails++; $display("FAIL peak_entry: got n=%0d e=%h expected 1 %h", got.size(), (got.size() > 0) ? got[0] : 24'h0, ent(15, 200)); end
    tests++; if (max_count !== 8'd1 || overflow !== 1'b0) begin
      fails++; $display("FAIL peak_stats: got mc=%0d ovf=%b expected 1 0", max_count, overflow); end
  endtask

  task automatic test_overflow();
    bit seen;
    int early;
    got.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 36; k++) drive_pix(k, 1'b1, k);
    early = 0;
    for (int i = 0; i < 4; i++) begin
      if (frame_done) early++;
      cyc();
    end
    tests++; if (early != 0) begin fails++; $display("FAIL ovf_early_done: got %0d pulses expected 0", early); end
    out_ready = 1'b1;
    wait_done(40, seen);
    tests++; if (!seen) begin fails++; $display("FAIL ovf_done_timeout: got no pulse expected pulse"); end
    tests++; if (got.size() != 8) begin fails++; $display("FAIL ovf_count: got %0d entries expected 8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      tests++; if (got[i] !== ent(i, i)) begin fails++; $display("FAIL ovf_entry%0d: got %h expected %h", i, got[i], ent(i, i)); end
    end
    tests++; if (overflow !== 1'b1 || max_count !== 8'd36) begin
      fails++; $display("FAIL ovf_stats: got ovf=%b mc=%0d expected 1 36", overflow, max_count); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    got.delete();
    out_ready = 1'b1;
    cyc();
    tests++; if (max_count !== 8'd36 || overflow !== 1'b1) begin
      fails++; $display("FAIL b2b_hold: got mc=%0d ovf=%b expected 36 1", max_count, overflow); end
    drive_pix(0, 1'b0, 0);
    tests++; if (max_count !== 8'd0 || overflow !== 1'b0) begin
      fails++; $display("FAIL b2b_clear: got mc=%0d ovf=%b expected 0 0", max_count, overflow); end
    drive_pix(1, 1'b0, 0);
    drive_pix(2, 1'b1, 90);
    tests++; if (max_count !== 8'd1) begin fails++; $display("FAIL b2b_mc1: got %0d expected 1", max_count); end
    for (int k = 3; k < 10; k++) drive_pix(k, 1'b0, 0);
    drive_pix(10, 1'b1, 91);
    tests++; if (max_count !== 8'd2) begin fails++; $display("FAIL b2b_mc2: got %0d expected 2", max_count); end
    for (int k = 11; k < 36; k++) drive_pix(k, 1'b0, 0);
    wait_done(20, seen);
    tests++; if (!seen || got.size() != 2 || got[0] !== ent(2, 90) || got[1] !== ent(10, 91)) begin
      fails++; $display("FAIL b2b_entries: got seen=%b n=%0d expected 1 2 (%h %h)", seen, got.size(), ent(2, 90), ent(10, 91)); end
  endtask

  task automatic test_stall_backpressure();
    bit seen, hold;
    bit acc;
    logic [23:0] hold_val;
    int k;
    got.delete();
    k = 0; seen = 1'b0; hold = 1'b0; hold_val = '0;
    for (int it = 0; it < 600; it++) begin
      in_valid  = (k < 36) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_flag   = (k == 0 || k == 7 || k == 14 || k == 29 || k == 35);
      in_pixel  = in_flag ? 8'(k + 11) : 8'd0;
      out_ready = 1'($urandom_range(0, 1));
      if (hold) begin
        tests++; if (out_valid !== 1'b1 || {out_row, out_col, out_value} !== hold_val) begin
          fails++; $display("FAIL stall_head_stable: got v=%b %h expected 1 %h", out_valid, {out_row, out_col, out_value}, hold_val); end
      end
      hold     = out_valid && !out_ready;
      hold_val = {out_row, out_col, out_value};
      acc      = in_valid && in_ready;
      cyc();
      if (acc) k++;
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    cyc();
    tests++; if (!seen) begin fails++; $display("FAIL stall_done_timeout: got no pulse expected pulse"); end
    tests++; if (got.size() != 5) begin fails++; $display("FAIL stall_count: got %0d entries expected 5", got.size()); end
    if (got.size() == 5) begin
      tests++; if (got[0] !== ent(0, 11) || got[1] !== ent(7, 18) || got[2] !== ent(14, 25) ||
                   got[3] !== ent(29, 40) || got[4] !== ent(35, 46)) begin
        fails++; $display("FAIL stall_entries: got %h %h %h %h %h expected %h %h %h %h %h",
          got[0], got[1], got[2], got[3], got[4], ent(0, 11), ent(7, 18), ent(14, 25), ent(29, 40), ent(35, 46)); end
    end
  endtask

  task automatic test_full_simul();
    bit seen;
    got.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) drive_pix(k, 1'b1, k);
    out_ready = 1'b1;
    drive_pix(8, 1'b1, 8);
    out_ready = 1'b0;
    tests++; if (overflow !== 1'b0 || max_count !== 8'd9) begin
      fails++; $display("FAIL full_simul: got ovf=%b mc=%0d expected 0 9", overflow, max_count); end
    drive_pix(9, 1'b1, 9);
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL full_still8: got ovf=%b expected 1", overflow); end
    for (int k = 10; k < 36; k++) drive_pix(k, 1'b0, 0);
    out_ready = 1'b1;
    wait_done(40, seen);
    tests++; if (!seen || got.size() != 9) begin
      fails++; $display("FAIL full_count: got seen=%b n=%0d expected 1 9", seen, got.size()); end
    if (got.size() == 9) begin
      tests++; if (got[0] !== ent(0, 0) || got[1] !== ent(1, 1) || got[8] !== ent(8, 8)) begin
        fails++; $display("FAIL full_entries: got %h %h %h expected %h %h %h", got[0], got[1], got[8], ent(0, 0), ent(1, 1), ent(8, 8)); end
    end
    tests++; if (max_count !== 8'd10) begin fails++; $display("FAIL full_mc: got %0d expected 10", max_count); end
  endtask

  task automatic test_reset_midframe();
    bit seen;
    got.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) drive_pix(k, k < 3, 100 + k);
    tests++; if (out_valid !== 1'b1 || max_count !== 8'd3) begin
      fails++; $display("FAIL rstmid_pre: got v=%b mc=%0d expected 1 3", out_valid, max_count); end
    #2 rst = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || max_count !== 8'd0 || in_ready !== 1'b1 || frame_done !== 1'b0) begin
      fails++; $display("FAIL rstmid_immediate: got v=%b mc=%0d rdy=%b fd=%b expected 0 0 1 0", out_valid, max_count, in_ready, frame_done); end
    @(posedge clk);
    #1 rst = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 36; k++) drive_pix(k, k == 0 || k == 7, (k == 0) ? 77 : 88);
    wait_done(20, seen);
    tests++; if (!seen || got.size() != 2 || got[0] !== ent(0, 77) || got[1] !== ent(7, 88)) begin
      fails++; $display("FAIL rstmid_next_frame: got seen=%b n=%0d expected 1 2 (%h %h)", seen, got.size(), ent(0, 77), ent(7, 88)); end
    tests++; if (max_count !== 8'd2 || overflow !== 1'b0) begin
      fails++; $display("FAIL rstmid_stats: got mc=%0d ovf=%b expected 2 0", max_count, overflow); end
  endtask

  initial begin
    test_reset();
    test_single_peak();
    test_overflow();
    test_back_to_back();
    test_stall_backpressure();
    test_full_simul();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/local_maxima_collector.md
# local_maxima_collector

Downstream stage of the 6x6 local-maxima engine. Consumes the engine's raster-ordered per-pixel result stream (1-bit maximum flag plus the 8-bit pixel value), tracks row/column, and queues the coordinates and value of every flagged pixel in a small FIFO. The FIFO drains through a valid/ready port. The block asserts a one-cycle frame-completion pulse once a full frame has been consumed and its queue is empty.

## Interface
- `WIDTH`, default 6: pixels per row; column range 1..WIDTH.
- `HEIGHT`, default 6: rows per frame; row range 1..HEIGHT.
- `DEPTH`, default 8: FIFO entries; power of two, at least 2.
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `in_valid`, input, 1: `in_flag`/`in_pixel` carry a pixel this cycle.
- `in_ready`, output, 1: block accepts a pixel this cycle.
- `in_flag`, input, 1: pixel is a local maximum.
- `in_pixel`, input, 8: pixel value.
- `out_valid`, output, 1: FIFO head is presented.
- `out_ready`, input, 1: consumer takes the head this cycle.
- `out_row`, output, 8: row of the head entry, 1-based.
- `out_col`, output, 8: column of the head entry, 1-based.
- `out_value`, output, 8: pixel value of the head entry.
- `max_count`, output, 8: maxima flagged in the current/last frame; saturates at 255.
- `overflow`, output, 1: sticky flag; at least one maximum was dropped this frame.
- `frame_done`, output, 1: one-cycle pulse at frame completion.

## Operation
- Accept happens when `in_valid && in_ready`. Pop happens when `out_valid && out_ready`.
- FSM states:
  - IDLE: `in_ready`=1. The first accept moves to COLLECT and is itself processed as pixel (1,1).
  - COLLECT: `in_ready`=1. The accept of pixel (HEIGHT,WIDTH) moves to FLUSH.
  - FLUSH: `in_ready`=0. Waits until the FIFO is empty, then pulses `frame_done`=1 for one cycle and returns to IDLE.
- Position counters `row` and `col` start at (1,1).
  - On accept: if `col==WIDTH`, then `col`←1 and `row`←`row+1`; otherwise `col`←`col+1`.
  - After (HEIGHT,WIDTH) both counters return to (1,1).
  - Counters advance only on accept; an `in_valid`=0 cycle holds them (stall).
- Push is an accept with `in_flag`=1. It writes {row, col, `in_pixel`} of that pixel.
- Full handling:
  - The FIFO counts as full when it holds DEPTH entries and no pop occurs that cycle.
  - A push and a pop in the same cycle while holding DEPTH entries are both performed; occupancy stays at DEPTH.
  - A push while full is dropped and sets `overflow`=1.
- `max_count` increments (saturating) on every flagged accept, including dropped ones.
- At the IDLE→COLLECT accept, `max_count` and `overflow` are cleared before the first pixel is applied. A flagged first pixel therefore yields `max_count`=1.
- Outside that accept, `max_count` and `overflow` hold their values through FLUSH and IDLE so the last frame's result stays readable.
- Pop behaviour:
  - An empty FIFO gives `out_valid`=0.
  - `out_row`, `out_col` and `out_value` are don't-care while `out_valid`=0.
  - Head data is stable while `out_valid`=1 and `out_ready`=0.
- Occupancy counter is `clog2(DEPTH)+1` bits wide. Read and write pointers wrap modulo DEPTH.

## Timing
- Reset (asynchronous assert, synchronous to the edge on release) gives:
  - state=IDLE, `row`=`col`=1, FIFO empty, pointers 0;
  - outputs `in_ready`=1, `out_valid`=0, `max_count`=0, `overflow`=0, `frame_done`=0;
  - `out_row`=`out_col`=`out_value`=0.
- A reset assertion mid-frame discards FIFO contents and counters immediately; no `frame_done` is produced.
- Push→`out_valid` latency: one cycle. An entry written at edge N is visible after edge N.
- Pop: the head advances at the edge where the pop is sampled. The next entry, if any, is presented in the following cycle with no bubble.
- FLUSH entry: `in_ready` falls in the cycle after the final accept.
- Frame completion: `frame_done` is high for exactly one cycle. That cycle is the one after the FIFO becomes empty in FLUSH, or the cycle after entering FLUSH if the FIFO is already empty. `in_ready` returns to 1 in the cycle after the pulse.
- No combinational path from `in_valid` to `in_ready`. The `out_ready`→`in_ready` path is not required.

## Test plan
- **Single peak:** 36 pixels all 0 except (3,4)=200 flagged, `out_ready`=1. Required: one entry (3,4,200); `max_count`=1; `frame_done` pulses 2 cycles after the last accept; `overflow`=0.
- **Overflow:** all 36 pixels flagged, value=index, `out_ready`=0 until FLUSH. Required: the first 8 entries are (1,1,0)…(2,2,7); `overflow`=1; `max_count`=36; `frame_done` pulses only after 8 pops.
- **Stall and backpressure:** `in_valid` toggled randomly, `out_ready` 50% duty, 5 flags at known positions. Required: 5 entries in order with correct coordinates; head stays stable while `out_ready`=0.
- **Full with simultaneous push and pop:** fill the FIFO to 8 entries, then push a flagged pixel with `out_ready`=1 in the same cycle. Required: no drop; `overflow`=0; occupancy stays 8.
- **Reset mid-frame:** assert `rst`=0 at pixel 20 with 3 entries queued. Required: `out_valid`=0 and `max_count`=0 immediately; the next frame starts at (1,1).
- **Back-to-back frames:** second frame with 2 flags. Required: `max_count` reads the prior value until the first accept of the second frame, then counts 1, 2; `overflow` is cleared.
